// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor.
// A DIGIT-bit adder slice is reused over WIDTH/DIGIT cycles, least
// significant digit first. Subtraction is a + ~b + ~cin, so carry=1
// in subtract mode means "no borrow".
//
// Handshake: start is accepted only in IDLE (ignored while busy or done);
// busy is high for exactly WIDTH/DIGIT cycles while digits are processed;
// done is a single-cycle pulse in the cycle after the last digit edge, and
// sum/carry/overflow hold from done until the next accepted start.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int DIGITS = WIDTH / DIGIT;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Partial result holds only the digits already produced above the
    // current one; the current digit is merged in combinationally.
    localparam int RW     = (WIDTH > DIGIT) ? (WIDTH - DIGIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [RW-1:0]    res_sr;
    logic [WIDTH-1:0] res_next;
    logic             cy_r;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   dig_full;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             msb_cin;
    logic             last_digit;

    // Digit slice: DIGIT-bit add of the low digits plus the running carry.
    always_comb begin
        dig_full = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, cy_r};
        dig_sum  = dig_full[DIGIT-1:0];
        dig_cout = dig_full[DIGIT];
        // Carry into the top bit of the digit recovered from s = a ^ b ^ c.
        msb_cin  = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dig_sum[DIGIT-1];
        last_digit = (cnt == CW'(DIGITS - 1));
    end

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_next = dig_sum;
        end else begin : g_multi
            assign res_next = {dig_sum, res_sr};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_digit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // Operand capture, digit shifting and final result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cy_r     <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= mode ? ~b : b;
                        cy_r <= mode ? ~cin : cin;
                        cnt  <= '0;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_next[WIDTH-1 -: RW];
                    cy_r   <= dig_cout;
                    cnt    <= cnt + CW'(1);
                    if (last_digit) begin
                        sum      <= res_next;
                        carry    <= dig_cout;
                        overflow <= dig_cout ^ msb_cin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
